sha256_msg_padder: RTL and testbench
====================================

// Module: sha256_msg_padder
// PURPOSE
//  Front end for the double-SHA256 chunk pipeline. Accepts a byte-aligned message as a stream of
//  32-bit big-endian words and emits FIPS 180-4 padded 512-bit blocks: 0x80 terminator, zero fill,
//  64-bit bit-length. Output drives the 512-bit datain of the SHA-256 chunk core, one block per handshake.
// PARAMETERS
//  CHUNKSIZE  512  block width; only 512 is supported
//  LEN_W      64   bit-length counter width; the field is zero-extended to 64 bits when LEN_W < 64
// PORTS
//  clk        in   1          single clock, all logic rising-edge
//  reset      in   1          synchronous, active-low reset
//  in_valid   in   1          input word valid
//  in_ready   out  1          padder can accept a word
//  in_data    in   32         message word; first byte in [31:24]
//  in_nbytes  in   3          valid bytes in word, 1..4 (MSB-aligned); 0 legal only with in_last (empty tail)
//  in_last    in   1          final word of message
//  out_valid  out  1          out_block valid
//  out_ready  in   1          consumer accepts block
//  out_block  out  CHUNKSIZE  padded block; word 0 in [511:480]
//  out_last   out  1          block is final block of message
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=FILL, word index=0, bit-length=0, out_valid=0, out_last=0,
//    out_block=0, in_ready=1. A reset mid-message or mid-handshake discards all partial data. No block is emitted.
//  - Handshakes: a transfer occurs when valid&&ready at posedge. in_ready=!out_valid.
//    out_block and out_last are registered and held stable while out_valid&&!out_ready.
//  - Non-last words: in_nbytes must be 4; other values are undefined. Words fill index 0..15.
//    Accepting word 15 sets out_valid=1 on the next cycle with out_last=0.
//  - States:
//      FILL  - accept words; go to SEND on a full block or on in_last.
//      SEND  - out_valid=1; on acceptance go to EXTRA if an extra block is pending, else FILL.
//      EXTRA - out_valid=1, block = zeros + length; on acceptance go to FILL.
//  - On in_last with n=in_nbytes at index k:
//      - The n bytes are placed, then 0x80 at byte n. If n==4, 0x80 goes to word k+1 byte 0.
//      - Let t = index of the word holding 0x80.
//      - If t<=13: words t+1..13 are zero, words 14..15 = bit-length, out_last=1.
//      - If t is 14 or 15: the current block is zero-filled after 0x80 with out_last=0. EXTRA
//        follows: words 0..13 zero, 14..15 = length, out_last=1.
//      - If t==16 (n==4, k==15): the full data block is sent with out_last=0. EXTRA block =
//        0x80000000 in word 0, zeros, length.
//  - Bit-length = 8*(total bytes of message), accumulated per accepted word; wraps modulo 2^LEN_W.
//    Length and index clear after the last block is accepted.
//  - Latency: last input handshake to out_valid = 1 cycle. There is one idle input cycle per
//    emitted block (out_valid blocks in_ready).
//  - Simultaneous out acceptance and a new in_valid: the input word is not taken that cycle
//    (in_ready was 0). It is taken the next cycle.
// CONFIGURATION
//  SHA_PAD_BLKCNT_EN defined: adds output blk_cnt[15:0]. Reset value 0.
//    - Increments on each out handshake and saturates at 0xFFFF.
//    - Cleared to 0 the cycle after an out_last block is accepted.
//    - Also adds output len_ovf, a sticky 1 once the bit-length counter wraps; cleared like blk_cnt.
//  Undefined: neither port exists. Length wraps silently. Datapath behaviour is identical.
// TESTING
//  1 "abc": word 0x61626300, nbytes=3, last
//    -> one block 61626380_0..0_00000000_00000018, out_last=1. SHA core digest matches the known double hash.
//  2 55 bytes (13 full words + 3-byte last)
//    -> single block, 0x80 at byte 55, word15=0x000001B8, out_last=1.
//  3 56 bytes (14 full words, the last word flagged in_last)
//    -> block 1: data, word14=0x80000000, word15=0, out_last=0.
//    -> block 2: zeros, word15=0x000001C0, out_last=1.
//  4 Empty message: in_last, nbytes=0
//    -> block 80000000_0..0, length 0, out_last=1.
//  5 64 bytes, out_ready low for 5 cycles per block
//    -> out_block stable, in_ready=0 throughout.
//    -> block 2 = 80000000, zeros, word15=0x00000200.
//  6 Reset low after 7 words of a message, then "abc"
//    -> no partial block is emitted. The output is exactly the scenario-1 block. blk_cnt=0 after reset.

Source files
------------

// File: rtl/sha256_msg_padder.sv
// FIPS 180-4 message padder: 32-bit big-endian word stream in, 512-bit padded blocks out.
// Optional SHA_PAD_BLKCNT_EN adds the blk_cnt block counter and the sticky len_ovf flag.
module sha256_msg_padder #(
    parameter int CHUNKSIZE = 512,
    parameter int LEN_W     = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_data,
    input  logic [2:0]           in_nbytes,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CHUNKSIZE-1:0] out_block,
    output logic                 out_last
`ifdef SHA_PAD_BLKCNT_EN
    ,
    output logic [15:0]          blk_cnt,
    output logic                 len_ovf
`endif
);

    typedef enum logic [1:0] {S_FILL, S_SEND, S_EXTRA} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [31:0]       r_words [16];
    logic [3:0]        r_idx;
    logic [LEN_W-1:0]  r_len;
    logic              r_last;
    logic              r_extra;
    logic              r_extra_mark;

    logic [LEN_W-1:0]  w_len_inc;
    logic [LEN_W-1:0]  w_len_sum;
    logic [63:0]       w_len64;
    logic [63:0]       w_rlen64;
    logic [31:0]       w_mask;
    logic [31:0]       w_mark;
    logic [31:0]       w_last_word;
    logic              w_full;
    logic [4:0]        w_t;

    assign out_valid = (r_state != S_FILL);
    assign in_ready  = !out_valid;
    assign out_last  = r_last;

    assign w_len_inc   = LEN_W'({in_nbytes, 3'b000});
    assign w_len_sum   = r_len + w_len_inc;
    assign w_len64     = 64'(w_len_sum);
    assign w_rlen64    = 64'(r_len);
    assign w_full      = (in_nbytes == 3'd4);
    // Index of the word that receives the 0x80 terminator; 16 means it spills into the next block.
    assign w_t         = {1'b0, r_idx} + {4'd0, w_full};
    assign w_last_word = (in_data & w_mask) | w_mark;

    always_comb begin
        w_mask = 32'hFFFF_FFFF;
        w_mark = 32'h0000_0000;
        case (in_nbytes)
            3'd0: begin w_mask = 32'h0000_0000; w_mark = 32'h8000_0000; end
            3'd1: begin w_mask = 32'hFF00_0000; w_mark = 32'h0080_0000; end
            3'd2: begin w_mask = 32'hFFFF_0000; w_mark = 32'h0000_8000; end
            3'd3: begin w_mask = 32'hFFFF_FF00; w_mark = 32'h0000_0080; end
            default: begin w_mask = 32'hFFFF_FFFF; w_mark = 32'h0000_0000; end
        endcase
    end

    for (genvar gi = 0; gi < 16; gi++) begin : g_flat
        assign out_block[CHUNKSIZE-1-32*gi -: 32] = r_words[gi];
    end

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_FILL;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FILL:  if (in_valid && (in_last || r_idx == 4'd15)) w_state_next = S_SEND;
            S_SEND:  if (out_ready) w_state_next = r_extra ? S_EXTRA : S_FILL;
            S_EXTRA: if (out_ready) w_state_next = S_FILL;
            default: w_state_next = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) r_words[i] <= 32'h0;
            r_idx        <= 4'd0;
            r_len        <= '0;
            r_last       <= 1'b0;
            r_extra      <= 1'b0;
            r_extra_mark <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: if (in_valid) begin
                    r_len <= w_len_sum;
                    if (in_last) begin
                        r_words[r_idx] <= w_last_word;
                        if (w_full && r_idx != 4'd15) r_words[r_idx + 4'd1] <= 32'h8000_0000;
                        if (w_t <= 5'd13) begin
                            r_words[14] <= w_len64[63:32];
                            r_words[15] <= w_len64[31:0];
                            r_last      <= 1'b1;
                            r_extra     <= 1'b0;
                        end else begin
                            r_last       <= 1'b0;
                            r_extra      <= 1'b1;
                            r_extra_mark <= (w_t == 5'd16);
                        end
                    end else begin
                        r_words[r_idx] <= in_data;
                        r_idx          <= r_idx + 4'd1;
                        r_last         <= 1'b0;
                        r_extra        <= 1'b0;
                    end
                end
                S_SEND: if (out_ready) begin
                    r_idx <= 4'd0;
                    for (int i = 0; i < 16; i++) r_words[i] <= 32'h0;
                    if (r_extra) begin
                        // Preload the trailing length-only block while the data block leaves.
                        r_words[0]  <= r_extra_mark ? 32'h8000_0000 : 32'h0;
                        r_words[14] <= w_rlen64[63:32];
                        r_words[15] <= w_rlen64[31:0];
                        r_last      <= 1'b1;
                        r_extra     <= 1'b0;
                    end else begin
                        r_last <= 1'b0;
                        if (r_last) r_len <= '0;
                    end
                end
                S_EXTRA: if (out_ready) begin
                    for (int i = 0; i < 16; i++) r_words[i] <= 32'h0;
                    r_len        <= '0;
                    r_last       <= 1'b0;
                    r_extra_mark <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef SHA_PAD_BLKCNT_EN
    logic [15:0] r_blk_cnt;
    logic        r_len_ovf;
    logic        w_len_wrap;
    logic        w_out_fire;
    logic        w_in_fire;

    assign w_out_fire = out_valid && out_ready;
    assign w_in_fire  = in_valid && in_ready;
    assign w_len_wrap = (w_len_sum < r_len);
    assign blk_cnt    = r_blk_cnt;
    assign len_ovf    = r_len_ovf;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_blk_cnt <= 16'h0;
            r_len_ovf <= 1'b0;
        end else if (w_out_fire && r_last) begin
            r_blk_cnt <= 16'h0;
            r_len_ovf <= 1'b0;
        end else begin
            if (w_out_fire && r_blk_cnt != 16'hFFFF) r_blk_cnt <= r_blk_cnt + 16'd1;
            if (w_in_fire && w_len_wrap) r_len_ovf <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: random messages checked against a byte-level FIPS 180-4 padding model.
module tb_sha256_msg_padder;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic [2:0]   in_nbytes;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] out_block;
    logic         out_last;
`ifdef SHA_PAD_BLKCNT_EN
    logic [15:0]  blk_cnt;
    logic         len_ovf;
`endif

    int           total = 0;
    int           bad = 0;
    logic [512:0] exp_q[$];
    logic [512:0] mdl_q[$];
    logic [7:0]   msg[$];
    bit           chk_en = 0;
    int           rdy_mode = 0;
    int           hold = 0;
    bit           hs_seen = 0;
    bit           prev_stall = 0;
    logic [511:0] prev_blk;
    logic         prev_last;
    logic [512:0] cmp_e;
    logic [512:0] pin_tmp;

    sha256_msg_padder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_nbytes (in_nbytes),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .out_last  (out_last)
`ifdef SHA_PAD_BLKCNT_EN
        ,
        .blk_cnt   (blk_cnt),
        .len_ovf   (len_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Consumer: mode 0 always ready, mode 1 random, mode 2 stalls each block for 5 cycles.
    always @(negedge clk) hs_seen = out_valid && out_ready;
    always @(posedge clk) begin
        #1;
        if (!out_valid || hs_seen) hold = 0;
        if (out_valid) hold++;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = (hold > 5);
        endcase
    end

    always @(negedge clk) begin
        if (!chk_en) begin
            prev_stall = 0;
        end else begin
            total++;
            if (in_ready !== !out_valid) begin
                bad++;
                $display("FAIL in_ready: got %b want %b", in_ready, !out_valid);
            end
            if (prev_stall) begin
                total++;
                if (out_valid !== 1'b1 || out_block !== prev_blk || out_last !== prev_last) begin
                    bad++;
                    $display("FAIL hold: got v=%b last=%b blk=%h want v=1 last=%b blk=%h",
                             out_valid, out_last, out_block, prev_last, prev_blk);
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL block: got unexpected block %h want none", out_block);
                end else begin
                    cmp_e = exp_q.pop_front();
                    if ({out_last, out_block} !== cmp_e) begin
                        bad++;
                        $display("FAIL block: got last=%b %h want last=%b %h",
                                 out_last, out_block, cmp_e[512], cmp_e[511:0]);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_blk   = out_block;
            prev_last  = out_last;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic finish_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    task automatic check(input string name, input logic [512:0] got, input logic [512:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic do_reset();
        chk_en   = 0;
        in_valid = 1'b0;
        reset    = 1'b0;
        step();
        step();
        @(negedge clk);
        check("rst_out_valid", 513'(out_valid), 513'(0));
        check("rst_in_ready", 513'(in_ready), 513'(1));
        check("rst_out_last", 513'(out_last), 513'(0));
        check("rst_out_block", 513'(out_block), 513'(0));
`ifdef SHA_PAD_BLKCNT_EN
        check("rst_blk_cnt", 513'(blk_cnt), 513'(0));
`endif
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        chk_en = 1;
    endtask

    // Reference: pad the whole byte string per FIPS 180-4, then cut into 64-byte blocks.
    task automatic model_msg();
        logic [7:0]   pad[$];
        logic [63:0]  bl;
        logic [511:0] blk;
        int           nb;
        pad = msg;
        pad.push_back(8'h80);
        while (pad.size() % 64 != 56) pad.push_back(8'h00);
        bl = 64'(msg.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) pad.push_back(bl[8*i +: 8]);
        nb = pad.size() / 64;
        mdl_q.delete();
        for (int b = 0; b < nb; b++) begin
            blk = '0;
            for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = pad[64*b+j];
            mdl_q.push_back({(b == nb - 1), blk});
        end
    endtask

    task automatic commit_model();
        foreach (mdl_q[i]) exp_q.push_back(mdl_q[i]);
    endtask

    task automatic rand_msg(input int len);
        msg.delete();
        for (int i = 0; i < len; i++) msg.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic put_word(input logic [31:0] d, input logic [2:0] n, input logic l);
        int   waitc;
        logic got;
        waitc     = 0;
        got       = 1'b0;
        in_valid  = 1'b1;
        in_data   = d;
        in_nbytes = n;
        in_last   = l;
        while (!got) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            waitc++;
            if (!got && waitc > 200) begin
                bad++;
                $display("FAIL in_wait: got in_ready=0 for %0d cycles want 1", waitc);
                finish_run();
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drive_msg(input int max_words, input bit tail_empty);
        int          len;
        int          nwt;
        int          n;
        logic [31:0] d;
        len = msg.size();
        if (len % 4 == 0 && (tail_empty || len == 0)) nwt = len / 4 + 1;
        else nwt = (len + 3) / 4;
        for (int w = 0; w < nwt && w < max_words; w++) begin
            n = len - 4 * w;
            if (n > 4) n = 4;
            if (n < 0) n = 0;
            d = $urandom();
            for (int b = 0; b < n; b++) d[31-8*b -: 8] = msg[4*w+b];
            put_word(d, 3'(n), (w == nwt - 1));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) step();
        end
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while (exp_q.size() != 0) begin
            step();
            c++;
            if (c > 1000) begin
                bad++;
                $display("FAIL drain: got %0d blocks outstanding want 0", exp_q.size());
                finish_run();
            end
        end
        repeat (3) step();
    endtask

    task automatic set_abc();
        msg.delete();
        msg.push_back(8'h61);
        msg.push_back(8'h62);
        msg.push_back(8'h63);
    endtask

    initial begin
        int lens[12];
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        in_nbytes = 3'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        rdy_mode  = 0;
        do_reset();

        set_abc();
        model_msg();
        check("pin_abc", mdl_q[0], {1'b1, 32'h61626380, 416'h0, 64'h18});
        commit_model();
        drive_msg(100, 0);
        wait_drain();

        rdy_mode = 1;
        rand_msg(55);
        model_msg();
        check("pin55_cnt", 513'(mdl_q.size()), 513'(1));
        pin_tmp = mdl_q[0];
        check("pin55_len", 513'(pin_tmp[31:0]), 513'(32'h1B8));
        check("pin55_pad", 513'(pin_tmp[71:64]), 513'(8'h80));
        commit_model();
        drive_msg(100, 0);
        wait_drain();

        rand_msg(56);
        model_msg();
        check("pin56_cnt", 513'(mdl_q.size()), 513'(2));
        pin_tmp = mdl_q[0];
        check("pin56_w14", 513'(pin_tmp[63:0]), 513'(64'h8000_0000_0000_0000));
        check("pin56_last0", 513'(pin_tmp[512]), 513'(0));
        check("pin56_blk1", mdl_q[1], {1'b1, 448'h0, 64'h1C0});
        commit_model();
        drive_msg(100, 0);
        wait_drain();

        rdy_mode = 0;
        msg.delete();
        model_msg();
        check("pin_empty", mdl_q[0], {1'b1, 32'h8000_0000, 416'h0, 64'h0});
        commit_model();
        drive_msg(100, 1);
        wait_drain();

        rdy_mode = 2;
        rand_msg(64);
        model_msg();
        check("pin64_blk1", mdl_q[1], {1'b1, 32'h8000_0000, 416'h0, 64'h200});
        commit_model();
        drive_msg(100, 0);
        wait_drain();

        rdy_mode = 1;
        rand_msg(40);
        drive_msg(7, 0);
        do_reset();
        set_abc();
        model_msg();
        commit_model();
        drive_msg(100, 0);
        wait_drain();

        lens = '{52, 59, 60, 61, 63, 64, 119, 120, 124, 128, 4, 8};
        foreach (lens[i]) begin
            rdy_mode = $urandom_range(0, 1);
            rand_msg(lens[i]);
            model_msg();
            commit_model();
            drive_msg(100, 1'($urandom_range(0, 1)));
        end
        for (int m = 0; m < 20; m++) begin
            rdy_mode = $urandom_range(0, 2);
            rand_msg($urandom_range(0, 130));
            model_msg();
            commit_model();
            drive_msg(100, 1'($urandom_range(0, 1)));
        end
        wait_drain();
        finish_run();
    end

endmodule
